// File: rtl/max_seq_driver.sv
// Initiator for the start/done max-compare responder: fetches N operands, reduces them to their maximum.
// Optional build macro MAX_DRV_TIMEOUT_EN adds a rsp_done watchdog that aborts to EMIT with out_err=1.
//
// state | meaning
// IDLE  | waiting for a length command
// FIRST | fetching the first operand; it seeds the running max
// FETCH | fetching the next operand and loading req_a/req_b
// ISSUE | one-cycle req_start pulse
// SKIP  | responder done is still stale from idle; ignore it
// WAIT  | waiting for rsp_done (optionally bounded by the watchdog)
// EMIT  | presenting out_max until out_ready
module max_seq_driver #(
    parameter int WIDTH       = 32,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             req_start,
    output logic [WIDTH-1:0] req_a,
    output logic [WIDTH-1:0] req_b,
    input  logic             rsp_done,
    input  logic [WIDTH-1:0] rsp_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_max,
    output logic             out_err,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FIRST,
        S_FETCH,
        S_ISSUE,
        S_SKIP,
        S_WAIT,
        S_EMIT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] remaining;
    logic [WIDTH-1:0] max_val;
    logic             last_elem;
    logic             timed_out;

    assign last_elem = (remaining == CNT_ONE);

`ifdef MAX_DRV_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] timer;

    // Down-counter loaded in SKIP so WAIT lasts at most TIMEOUT_CYC cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer <= '0;
        end else if (state == S_SKIP) begin
            timer <= TO_LOAD;
        end else if (state == S_WAIT && timer != '0) begin
            timer <= timer - TO_W'(1);
        end
    end

    assign timed_out = (state == S_WAIT) && !rsp_done && (timer == '0);
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_next = (cmd_len == '0) ? S_EMIT : S_FIRST;
                end
            end
            S_FIRST: begin
                if (in_valid) begin
                    state_next = last_elem ? S_EMIT : S_FETCH;
                end
            end
            S_FETCH: begin
                if (in_valid) begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: state_next = S_SKIP;
            S_SKIP:  state_next = S_WAIT;
            S_WAIT: begin
                if (rsp_done) begin
                    state_next = last_elem ? S_EMIT : S_FETCH;
                end else if (timed_out) begin
                    state_next = S_EMIT;
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign cmd_ready = (state == S_IDLE);
    assign in_ready  = (state == S_FIRST) || (state == S_FETCH);
    assign req_start = (state == S_ISSUE);
    assign out_valid = (state == S_EMIT);
    assign busy      = (state != S_IDLE);

    // req_a/req_b load only in FETCH, so they hold from ISSUE until WAIT exits.
    always_ff @(posedge clk) begin
        if (reset) begin
            remaining <= '0;
            max_val   <= '0;
            req_a     <= '0;
            req_b     <= '0;
            out_max   <= '0;
            out_err   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        remaining <= cmd_len;
                        max_val   <= '0;
                        out_err   <= 1'b0;
                        if (cmd_len == '0) begin
                            out_max <= '0;
                        end
                    end
                end
                S_FIRST: begin
                    if (in_valid) begin
                        max_val   <= in_data;
                        remaining <= remaining - CNT_ONE;
                        if (last_elem) begin
                            out_max <= in_data;
                        end
                    end
                end
                S_FETCH: begin
                    if (in_valid) begin
                        req_a <= max_val;
                        req_b <= in_data;
                    end
                end
                S_WAIT: begin
                    if (rsp_done) begin
                        max_val   <= rsp_result;
                        remaining <= remaining - CNT_ONE;
                        if (last_elem) begin
                            out_max <= rsp_result;
                        end
                    end else if (timed_out) begin
                        out_max <= max_val;
                        out_err <= 1'b1;
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        out_err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_max_seq_driver.sv
// Scoreboard bench for max_seq_driver with a latency-programmable responder model.
// Define MAX_DRV_TIMEOUT_EN for both DUT and bench to exercise the watchdog.
module tb_max_seq_driver;

    localparam int WIDTH = 32;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [CNT_W-1:0] cmd_len;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             req_start;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             rsp_done;
    logic [WIDTH-1:0] rsp_result;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_max;
    logic             out_err;
    logic             busy;

    max_seq_driver #(.WIDTH(WIDTH), .CNT_W(CNT_W), .TIMEOUT_CYC(64)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .req_start(req_start), .req_a(req_a), .req_b(req_b),
        .rsp_done(rsp_done), .rsp_result(rsp_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_max(out_max),
        .out_err(out_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboards: expected compare pairs {a,b} and expected results {err,max}.
    logic [2*WIDTH-1:0] pair_q[$];
    logic [WIDTH:0]     res_q[$];

    logic [WIDTH-1:0] model_max;
    int               rsp_lat = 1;
    bit               rsp_hang = 1'b0;
    int               start_cnt = 0;
    int               rsp_cnt = 0;
    bit               cap_pending = 1'b0;
    logic [WIDTH-1:0] start_a, start_b, pend_res;

    // Responder: samples operands one cycle after start, raises done rsp_lat cycles after start.
    always @(negedge clk) begin
        logic [2*WIDTH-1:0] exp_pair;
        if (cap_pending) begin
            check_val("hold_a", req_a, start_a);
            check_val("hold_b", req_b, start_b);
            if (pair_q.size() == 0) begin
                check_val("pair_unexpected", 1, 0);
            end else begin
                exp_pair = pair_q.pop_front();
                check_val("req_a", req_a, exp_pair[2*WIDTH-1:WIDTH]);
                check_val("req_b", req_b, exp_pair[WIDTH-1:0]);
            end
            pend_res = (req_a > req_b) ? req_a : req_b;
            cap_pending = 1'b0;
        end
        if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0 && !rsp_hang) begin
                rsp_done   = 1'b1;
                rsp_result = pend_res;
            end
        end
        if (req_start) begin
            start_cnt++;
            rsp_done    = 1'b0;
            start_a     = req_a;
            start_b     = req_b;
            cap_pending = 1'b1;
            rsp_cnt     = rsp_lat;
        end
    end

    task automatic send_cmd(input int len);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_len   = CNT_W'(len);
        while (!cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_val("cmd_accept", cmd_ready, 1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Returns at the negedge after the accepting posedge.
    task automatic feed(input logic [WIDTH-1:0] d, input bit first);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_val("in_accept", in_ready, 1);
        if (first) begin
            model_max = d;
        end else begin
            pair_q.push_back({model_max, d});
            if (d > model_max) model_max = d;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic accept_out(input int hold);
        int n = 0;
        logic [WIDTH:0] exp;
        while (!out_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_val("out_valid_seen", out_valid, 1);
        exp = (res_q.size() != 0) ? res_q.pop_front() : '0;
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1;
            check_val("stall_valid", out_valid, 1);
            check_val("stall_max", out_max, exp[WIDTH-1:0]);
            check_val("stall_cmd_ready", cmd_ready, 0);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        out_ready = 1'b1;
        check_val("out_max", out_max, exp[WIDTH-1:0]);
        check_val("out_err", out_err, exp[WIDTH]);
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check_val("out_valid_drop", out_valid, 0);
        check_val("busy_idle", busy, 0);
        check_val("err_clear", out_err, 0);
    endtask

    task automatic run_cmd(input logic [WIDTH-1:0] data[$], input int hold);
        int s0;
        logic [WIDTH-1:0] m = '0;
        foreach (data[i]) if (data[i] > m) m = data[i];
        res_q.push_back({1'b0, m});
        s0 = start_cnt;
        send_cmd(data.size());
        if (data.size() == 0) begin
            check_val("len0_latency", out_valid, 1);
        end
        foreach (data[i]) feed(data[i], i == 0);
        accept_out(hold);
        check_val("start_pulses", start_cnt - s0, (data.size() > 0) ? data.size() - 1 : 0);
    endtask

    initial begin
        logic [WIDTH-1:0] d[$];
        reset = 1'b1; cmd_valid = 1'b0; cmd_len = '0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b0; rsp_done = 1'b1; rsp_result = '0; model_max = '0;
        repeat (3) @(negedge clk);
        check_val("rst_busy", busy, 0);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_req_start", req_start, 0);
        check_val("rst_out_max", out_max, 0);
        check_val("rst_req_a", req_a, 0);
        check_val("rst_cmd_ready", cmd_ready, 1);
        reset = 1'b0;

        d = {}; run_cmd(d, 0);                                        // T1
        d = {32'd7}; run_cmd(d, 0);                                   // T2
        rsp_lat = 3; d = {32'd3, 32'd9, 32'd2, 32'd9}; run_cmd(d, 0); // T3
        rsp_lat = 1; d = {32'hFFFF_FFFF, 32'd1}; run_cmd(d, 10);      // T4
        d = {32'd5, 32'd5, 32'd5}; run_cmd(d, 2);
        d = {32'd1, 32'h8000_0000, 32'h7FFF_FFFF}; run_cmd(d, 0);
        for (int r = 0; r < 3; r++) begin
            d = {};
            for (int i = 0; i < 5; i++) d.push_back($urandom);
            rsp_lat = $urandom_range(1, 6);
            run_cmd(d, $urandom_range(0, 3));
        end

        // T5: reset while waiting on the responder
        rsp_lat = 20;
        send_cmd(3);
        feed(32'd5, 1'b1);
        feed(32'd9, 1'b0);
        repeat (3) @(negedge clk);
        check_val("t5_in_wait", busy, 1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("t5_busy", busy, 0);
        check_val("t5_out_valid", out_valid, 0);
        check_val("t5_cmd_ready", cmd_ready, 1);
        reset = 1'b0;
        repeat (25) @(negedge clk);
        rsp_lat = 2;
        d = {32'd5, 32'd6}; run_cmd(d, 0);

`ifdef MAX_DRV_TIMEOUT_EN
        begin : t6
            int n = 0;
            rsp_hang = 1'b1;
            res_q.push_back({1'b1, 32'd4});
            send_cmd(3);
            feed(32'd4, 1'b1);
            feed(32'd8, 1'b0);
            while (!out_valid && n < 200) begin
                @(negedge clk);
                n++;
            end
            check_val("t6_timeout_cycles", n, 66);
            accept_out(0);
            rsp_hang = 1'b0;
            rsp_done = 1'b1;
        end
`endif

        repeat (3) @(negedge clk);
        check_val("pairs_drained", pair_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
